lamp_ramp_ctrl: RTL and testbench

Sequential lamp driver that sits directly downstream of the active-lamp count stage in the smart home system. It consumes the requested number of active lamps (0–15) and drives a thermometer-coded bank of lamp enables. The bank ramps toward the request one lamp per step interval, so rooms brighten and dim gradually instead of switching all lamps at once. A settle filter ignores glitches while the upstream time code or user setting changes.

---
 rtl/lamp_ramp_ctrl.sv | 158 +++++++++++++++
 tb/tb_lamp_ramp_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lamp_ramp_ctrl.sv
// Lamp bank driver: settles the requested lamp count, then ramps a thermometer-coded
// enable bank toward it one lamp per step interval.
module lamp_ramp_ctrl #(
  parameter int unsigned MAX_LAMPS     = 15,
  parameter int unsigned STEP_CYCLES   = 1000,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  active_lights,
  input  logic        enable,
  output logic [14:0] lamp_en,
  output logic [3:0]  lamp_count,
  output logic        busy,
  output logic        at_target
);

  localparam int unsigned STEP_W   = (STEP_CYCLES > 32'd1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 32'd1);

  localparam logic [STEP_W-1:0]   STEP_LAST   = STEP_W'(STEP_CYCLES - 32'd1);
  localparam logic [STEP_W-1:0]   STEP_ONE    = STEP_W'(1'b1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 32'd1);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX  = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1'b1);
  localparam logic [3:0]          MAX_CNT     = 4'(MAX_LAMPS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  logic [3:0]          candidate_r;
  logic [SETTLE_W-1:0] stable_r;
  logic [3:0]          target_r;
  logic [STEP_W-1:0]   step_r;
  logic [3:0]          lamp_count_r;
  logic [14:0]         lamp_en_r;
  logic                busy_r;
  logic                at_target_r;

  logic                match_s;
  logic                load_s;
  logic                target_chg_s;
  logic [3:0]          clamp_s;
  logic [3:0]          target_nxt_s;
  logic [SETTLE_W-1:0] stable_nxt_s;
  logic [1:0]          state_s;
  logic [3:0]          lamp_nxt_s;
  logic [STEP_W-1:0]   step_nxt_s;

  // Lamps at or above MAX_LAMPS never light, even if the count were out of range.
  function automatic logic [14:0] thermo(input logic [3:0] cnt);
    logic [14:0] t;
    t = 15'd0;
    for (int i = 0; i < 15; i++) begin
      if ((i < int'(cnt)) && (i < int'(MAX_LAMPS))) t[i] = 1'b1;
      else t[i] = 1'b0;
    end
    return t;
  endfunction

  // Settle filter: a request is accepted once it has matched the sampled copy long enough.
  always_comb begin
    match_s      = (active_lights == candidate_r);
    load_s       = match_s && (stable_r == SETTLE_LAST);
    clamp_s      = candidate_r;
    stable_nxt_s = stable_r;
    if (int'(candidate_r) > int'(MAX_LAMPS)) clamp_s = MAX_CNT;
    else clamp_s = candidate_r;
    if (!match_s) stable_nxt_s = '0;
    else if (stable_r == SETTLE_MAX) stable_nxt_s = stable_r;
    else stable_nxt_s = stable_r + SETTLE_ONE;
    target_chg_s = load_s && (clamp_s != target_r);
    if (load_s) target_nxt_s = clamp_s;
    else target_nxt_s = target_r;
  end

  // Ramp direction is derived fresh every cycle from the count/target comparison.
  always_comb begin
    state_s = ST_IDLE;
    if (lamp_count_r < target_r) state_s = ST_UP;
    else if (lamp_count_r > target_r) state_s = ST_DOWN;
    else state_s = ST_IDLE;
  end

  // Step engine; a fresh target wins over a coincident terminal count.
  always_comb begin
    lamp_nxt_s = lamp_count_r;
    step_nxt_s = '0;
    if (!enable) begin
      lamp_nxt_s = 4'd0;
      step_nxt_s = '0;
    end else if (target_chg_s) begin
      lamp_nxt_s = lamp_count_r;
      step_nxt_s = '0;
    end else begin
      case (state_s)
        ST_UP: begin
          if (step_r == STEP_LAST) begin
            step_nxt_s = '0;
            if (int'(lamp_count_r) < int'(MAX_LAMPS)) lamp_nxt_s = lamp_count_r + 4'd1;
            else lamp_nxt_s = lamp_count_r;
          end else begin
            step_nxt_s = step_r + STEP_ONE;
            lamp_nxt_s = lamp_count_r;
          end
        end
        ST_DOWN: begin
          if (step_r == STEP_LAST) begin
            step_nxt_s = '0;
            if (lamp_count_r != 4'd0) lamp_nxt_s = lamp_count_r - 4'd1;
            else lamp_nxt_s = lamp_count_r;
          end else begin
            step_nxt_s = step_r + STEP_ONE;
            lamp_nxt_s = lamp_count_r;
          end
        end
        ST_IDLE: begin
          step_nxt_s = '0;
          lamp_nxt_s = lamp_count_r;
        end
        default: begin
          step_nxt_s = '0;
          lamp_nxt_s = lamp_count_r;
        end
      endcase
    end
  end

  // State and outputs; status flags decode next-state values to stay aligned with the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      candidate_r  <= 4'd0;
      stable_r     <= '0;
      target_r     <= 4'd0;
      step_r       <= '0;
      lamp_count_r <= 4'd0;
      lamp_en_r    <= 15'd0;
      busy_r       <= 1'b0;
      at_target_r  <= 1'b0;
    end else begin
      candidate_r  <= active_lights;
      stable_r     <= stable_nxt_s;
      target_r     <= target_nxt_s;
      step_r       <= step_nxt_s;
      lamp_count_r <= lamp_nxt_s;
      lamp_en_r    <= thermo(lamp_nxt_s);
      busy_r       <= enable && (lamp_nxt_s != target_nxt_s);
      at_target_r  <= enable && (lamp_nxt_s == target_nxt_s);
    end
  end

  assign lamp_en    = lamp_en_r;
  assign lamp_count = lamp_count_r;
  assign busy       = busy_r;
  assign at_target  = at_target_r;

endmodule

// File: tb/tb_lamp_ramp_ctrl.sv
// Scoreboard bench: two instances (15 and 10 lamps) share scripted and random stimulus,
// a behavioural model predicts each edge, a negedge monitor compares.
module tb_lamp_ramp_ctrl;

  localparam int STEP   = 4;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  active_lights;
  logic        enable;
  logic [14:0] lamp_en_a, lamp_en_b;
  logic [3:0]  lamp_count_a, lamp_count_b;
  logic        busy_a, busy_b, at_target_a, at_target_b;

  lamp_ramp_ctrl #(.MAX_LAMPS(15), .STEP_CYCLES(STEP), .SETTLE_CYCLES(SETTLE)) dut_a (
    .clk(clk), .rst_n(rst_n), .active_lights(active_lights), .enable(enable),
    .lamp_en(lamp_en_a), .lamp_count(lamp_count_a), .busy(busy_a), .at_target(at_target_a));

  lamp_ramp_ctrl #(.MAX_LAMPS(10), .STEP_CYCLES(STEP), .SETTLE_CYCLES(SETTLE)) dut_b (
    .clk(clk), .rst_n(rst_n), .active_lights(active_lights), .enable(enable),
    .lamp_en(lamp_en_b), .lamp_count(lamp_count_b), .busy(busy_b), .at_target(at_target_b));

  always #5 clk = ~clk;

  typedef struct {
    int cand;
    int stable;
    int target;
    int lamp;
    int step;
  } mdl_t;

  typedef struct {
    int cyc;
    int cnt_a;
    int len_a;
    int busy_a;
    int at_a;
    int cnt_b;
    int len_b;
    int busy_b;
    int at_b;
  } exp_t;

  mdl_t ma, mb;
  exp_t q[$];
  int   edge_no = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) edge_no <= edge_no + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
               name, act, act, exp, exp, edge_no);
    end
  endtask

  function automatic mdl_t mdl_zero();
    mdl_t m;
    m.cand = 0; m.stable = 0; m.target = 0; m.lamp = 0; m.step = 0;
    return m;
  endfunction

  // One clock edge of the specified behaviour, in plain arithmetic.
  function automatic mdl_t mdl_step(mdl_t m, int a, bit en, int maxl);
    mdl_t n;
    bit   load;
    int   newt;
    n    = m;
    load = (a == m.cand) && (m.stable == SETTLE - 1);
    newt = (a > maxl) ? maxl : a;
    if (a == m.cand) n.stable = (m.stable < SETTLE) ? m.stable + 1 : SETTLE;
    else n.stable = 0;
    n.cand = a;
    if (!en) begin
      n.lamp = 0;
      n.step = 0;
    end else if (load && newt != m.target) begin
      n.step = 0;
    end else if (m.lamp != m.target) begin
      if (m.step == STEP - 1) begin
        n.step = 0;
        n.lamp = (m.lamp < m.target) ? m.lamp + 1 : m.lamp - 1;
      end else begin
        n.step = m.step + 1;
      end
    end else begin
      n.step = 0;
    end
    if (load) n.target = newt;
    return n;
  endfunction

  function automatic exp_t mk_exp(int cyc, bit en, bit in_rst);
    exp_t e;
    e.cyc = cyc;
    if (in_rst) begin
      e.cnt_a = 0; e.len_a = 0; e.busy_a = 0; e.at_a = 0;
      e.cnt_b = 0; e.len_b = 0; e.busy_b = 0; e.at_b = 0;
    end else begin
      e.cnt_a  = ma.lamp;
      e.len_a  = (1 << ma.lamp) - 1;
      e.busy_a = (en && ma.lamp != ma.target) ? 1 : 0;
      e.at_a   = (en && ma.lamp == ma.target) ? 1 : 0;
      e.cnt_b  = mb.lamp;
      e.len_b  = (1 << mb.lamp) - 1;
      e.busy_b = (en && mb.lamp != mb.target) ? 1 : 0;
      e.at_b   = (en && mb.lamp == mb.target) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic tick(input int a, input bit en);
    active_lights = 4'(a);
    enable        = en;
    ma = mdl_step(ma, a, en, 15);
    mb = mdl_step(mb, a, en, 10);
    q.push_back(mk_exp(edge_no + 1, en, 1'b0));
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int a, input bit en, input int n);
    for (int i = 0; i < n; i++) tick(a, en);
  endtask

  // Monitor: compare every expectation whose edge has occurred.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= edge_no) begin
      exp_t e;
      e = q.pop_front();
      chk("count_a",  int'(lamp_count_a), e.cnt_a);
      chk("lampen_a", int'(lamp_en_a),    e.len_a);
      chk("busy_a",   int'(busy_a),       e.busy_a);
      chk("attgt_a",  int'(at_target_a),  e.at_a);
      chk("count_b",  int'(lamp_count_b), e.cnt_b);
      chk("lampen_b", int'(lamp_en_b),    e.len_b);
      chk("busy_b",   int'(busy_b),       e.busy_b);
      chk("attgt_b",  int'(at_target_b),  e.at_b);
    end
  end

  initial begin
    int lim;
    rst_n         = 1'b0;
    enable        = 1'b0;
    active_lights = 4'd0;
    ma = mdl_zero();
    mb = mdl_zero();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(lamp_count_a), 0);
    chk("rst_lampen", int'(lamp_en_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_attgt", int'(at_target_a), 0);
    rst_n = 1'b1;

    // Ramp up to 5.
    hold(5, 1'b1, 30);
    chk("up5_count", int'(lamp_count_a), 5);
    chk("up5_lampen", int'(lamp_en_a), 32'h001F);
    chk("up5_busy", int'(busy_a), 0);
    chk("up5_attgt", int'(at_target_a), 1);

    // Dim to 2.
    hold(2, 1'b1, 20);
    chk("dn2_lampen", int'(lamp_en_a), 32'h0003);

    // Glitch rejection at steady 3.
    hold(3, 1'b1, 20);
    tick(9, 1'b1);
    hold(3, 1'b1, 12);
    chk("glitch_count", int'(lamp_count_a), 3);

    // Reversal mid-ramp.
    hold(0, 1'b1, 20);
    lim = 0;
    while (ma.lamp != 4 && lim < 100) begin
      tick(8, 1'b1);
      lim++;
    end
    chk("reach4", int'(lamp_count_a), 4);
    hold(1, 1'b1, 20);
    chk("rev_count", int'(lamp_count_a), 1);

    // Enable drop at 6 and re-raise.
    lim = 0;
    while (ma.lamp != 6 && lim < 100) begin
      tick(6, 1'b1);
      lim++;
    end
    chk("reach6", int'(lamp_count_a), 6);
    tick(6, 1'b0);
    chk("dis_count", int'(lamp_count_a), 0);
    chk("dis_lampen", int'(lamp_en_a), 0);
    hold(6, 1'b1, 30);
    chk("reen_count", int'(lamp_count_a), 6);

    // Clamp: request 15 on both instances.
    hold(15, 1'b1, 70);
    chk("max15_lampen", int'(lamp_en_a), 32'h7FFF);
    chk("max10_count", int'(lamp_count_b), 10);
    chk("max10_lampen", int'(lamp_en_b), 32'h03FF);

    // Asynchronous reset mid-ramp.
    hold(4, 1'b1, 10);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_count", int'(lamp_count_a), 0);
    chk("arst_lampen", int'(lamp_en_a), 0);
    chk("arst_busy", int'(busy_a), 0);
    chk("arst_lampen_b", int'(lamp_en_b), 0);
    ma = mdl_zero();
    mb = mdl_zero();
    q.push_back(mk_exp(edge_no + 1, 1'b1, 1'b1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(4, 1'b1, 30);

    // Randomized requests with random hold lengths and occasional disable.
    for (int i = 0; i < 400; i++) begin
      int a;
      int d;
      bit en;
      a  = $urandom_range(0, 15);
      d  = $urandom_range(1, 12);
      en = ($urandom_range(0, 9) != 0);
      hold(a, en, d);
    end

    @(negedge clk);
    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
